gpio_rgb_packer: RTL and testbench

GPIO_RGB_PACKER -- requirements
Module: gpio_rgb_packer

---
 rtl/gpio_rgb_packer_if.sv | 25 ++
 rtl/gpio_rgb_packer.sv | 138 +++++++++++++
 tb/tb_gpio_rgb_packer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_rgb_packer_if.sv
// rtl/gpio_rgb_packer_if.sv - processor lane bus and pixel stream bundle for gpio_rgb_packer
interface gpio_rgb_packer_if;
  logic [127:0] GPIO;
  logic         GPIOEn;
  logic         GPIOEnR;
  logic         GPIOEnG;
  logic         GPIOEnB;
  logic [23:0]  pixel;
  logic         pixelValid;
  logic         pixelReady;
  logic [15:0]  pixelCount;
  logic         done;
  logic         seqErr;
  logic         ovfErr;

  modport slave (
    input  GPIO, GPIOEn, GPIOEnR, GPIOEnG, GPIOEnB, pixelReady,
    output pixel, pixelValid, pixelCount, done, seqErr, ovfErr
  );

  modport master (
    output GPIO, GPIOEn, GPIOEnR, GPIOEnG, GPIOEnB, pixelReady,
    input  pixel, pixelValid, pixelCount, done, seqErr, ovfErr
  );
endinterface

// File: rtl/gpio_rgb_packer.sv
// rtl/gpio_rgb_packer.sv - packs saturated R/G/B lane words into a 4-pixel output stream
module gpio_rgb_packer #(
  parameter int unsigned PIXEL_TOTAL = 40000
) (
  input  logic           clk,
  input  logic           rst,
  gpio_rgb_packer_if.slave bus
);
  typedef enum logic [2:0] {WAIT_START, WAIT_R, WAIT_G, WAIT_B, FULL} state_t;

  state_t      state, state_nxt;
  logic        en_r, en_g, en_b;
  logic        store_r, store_g, store_b, load, set_seq, set_ovf;
  logic        accept, buf_free;
  logic [31:0] sat_word;
  logic [31:0] cap_r, cap_g, cap_b;
  logic [31:0] out_r, out_g, out_b;
  logic [1:0]  idx;
  logic [4:0]  sh;
  logic        out_valid;
  logic [15:0] count;
  logic        seq_err, ovf_err;

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

  always_comb begin
    sat_word = '0;
    for (int k = 0; k < 4; k++)
      sat_word[8*k +: 8] = sat8(bus.GPIO[32*k +: 32]);
  end

  // GPIOEn outranks every colour enable, so colour decodes are masked by it
  assign en_r = !bus.GPIOEn && bus.GPIOEnR;
  assign en_g = !bus.GPIOEn && !bus.GPIOEnR && bus.GPIOEnG;
  assign en_b = !bus.GPIOEn && !bus.GPIOEnR && !bus.GPIOEnG && bus.GPIOEnB;

  assign accept   = out_valid && bus.pixelReady;
  assign buf_free = !out_valid || (accept && idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_START;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    store_r   = 1'b0;
    store_g   = 1'b0;
    store_b   = 1'b0;
    load      = 1'b0;
    set_seq   = 1'b0;
    set_ovf   = 1'b0;
    case (state)
      WAIT_START: begin
        if (bus.GPIOEn) state_nxt = WAIT_R;
      end
      WAIT_R: begin
        if (en_r) begin
          store_r   = 1'b1;
          state_nxt = WAIT_G;
        end else if (en_g || en_b) begin
          set_seq   = 1'b1;
          state_nxt = WAIT_R;
        end
      end
      WAIT_G: begin
        if (en_g) begin
          store_g   = 1'b1;
          state_nxt = WAIT_B;
        end else if (en_r || en_b) begin
          set_seq   = 1'b1;
          state_nxt = WAIT_R;
        end
      end
      WAIT_B: begin
        if (en_b) begin
          store_b   = 1'b1;
          state_nxt = FULL;
        end else if (en_r || en_g) begin
          set_seq   = 1'b1;
          state_nxt = WAIT_R;
        end
      end
      FULL: begin
        if (en_r || en_g || en_b) set_ovf = 1'b1;
        if (buf_free) begin
          load      = 1'b1;
          state_nxt = WAIT_R;
        end
      end
      default: state_nxt = WAIT_START;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_r     <= '0;
      cap_g     <= '0;
      cap_b     <= '0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      count     <= '0;
      seq_err   <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      if (store_r) cap_r <= sat_word;
      if (store_g) cap_g <= sat_word;
      if (store_b) cap_b <= sat_word;
      if (set_seq) seq_err <= 1'b1;
      if (set_ovf) ovf_err <= 1'b1;
      if (accept && count != 16'hFFFF) count <= count + 16'd1;
      // a load on the last-accept edge keeps the stream gap-free
      if (load) begin
        out_r     <= cap_r;
        out_g     <= cap_g;
        out_b     <= cap_b;
        idx       <= 2'd0;
        out_valid <= 1'b1;
      end else if (accept) begin
        if (idx == 2'd3) out_valid <= 1'b0;
        idx <= idx + 2'd1;
      end
    end
  end

  assign sh             = {idx, 3'b000};
  assign bus.pixel      = out_valid ? {out_r[sh +: 8], out_g[sh +: 8], out_b[sh +: 8]} : 24'h0;
  assign bus.pixelValid = out_valid;
  assign bus.pixelCount = count;
  assign bus.done       = ({16'h0, count} >= PIXEL_TOTAL);
  assign bus.seqErr     = seq_err;
  assign bus.ovfErr     = ovf_err;
endmodule

// File: tb/tb_gpio_rgb_packer.sv
// tb/tb_gpio_rgb_packer.sv - directed bench with reference model for gpio_rgb_packer
module tb_gpio_rgb_packer;
  localparam int PT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  gpio_rgb_packer_if bus();

  gpio_rgb_packer #(.PIXEL_TOTAL(PT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] lanes(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [7:0] satb(input logic [31:0] v);
    if (v > 255) return 8'hFF;
    return v[7:0];
  endfunction

  // reference model: colours collected so far, one held triple, queue of pending pixels
  bit              m_armed = 0;
  int              m_have  = 0;
  logic [7:0]      m_c[3][4];
  int unsigned     m_q[$];
  int              m_cnt   = 0;
  bit              m_seq   = 0;
  bit              m_ovf   = 0;

  always @(posedge clk or posedge rst) begin
    int col;
    bit was_full;
    if (rst) begin
      m_armed = 0;
      m_have  = 0;
      m_q.delete();
      m_cnt   = 0;
      m_seq   = 0;
      m_ovf   = 0;
    end else begin
      was_full = (m_have == 3);
      col = -1;
      if (!bus.GPIOEn) begin
        if (bus.GPIOEnR)      col = 0;
        else if (bus.GPIOEnG) col = 1;
        else if (bus.GPIOEnB) col = 2;
      end
      if (m_q.size() > 0 && bus.pixelReady) begin
        void'(m_q.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      if (!m_armed) begin
        if (bus.GPIOEn) begin
          m_armed = 1;
          m_have  = 0;
        end
      end else if (was_full) begin
        if (col >= 0) m_ovf = 1;
      end else if (col >= 0 && col == m_have) begin
        for (int k = 0; k < 4; k++) m_c[col][k] = satb(bus.GPIO[32*k +: 32]);
        m_have++;
      end else if (col >= 0) begin
        m_seq  = 1;
        m_have = 0;
      end
      if (was_full && m_q.size() == 0) begin
        for (int k = 0; k < 4; k++) m_q.push_back({8'h0, m_c[0][k], m_c[1][k], m_c[2][k]});
        m_have = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", bus.pixelValid, (m_q.size() > 0));
    if (m_q.size() > 0) chk("pixel", bus.pixel, m_q[0]);
    chk("count", bus.pixelCount, m_cnt);
    chk("done", bus.done, (m_cnt >= PT));
    chk("seqErr", bus.seqErr, m_seq);
    chk("ovfErr", bus.ovfErr, m_ovf);
  end

  task automatic step(input logic en, r, g, b, input logic [127:0] d);
    @(posedge clk);
    #2;
    bus.GPIOEn  = en;
    bus.GPIOEnR = r;
    bus.GPIOEnG = g;
    bus.GPIOEnB = b;
    bus.GPIO    = d;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0);
  endtask

  initial begin
    bus.GPIO = '0;
    bus.GPIOEn = 0;
    bus.GPIOEnR = 0;
    bus.GPIOEnG = 0;
    bus.GPIOEnB = 0;
    bus.pixelReady = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;

    // colour word without a start marker is ignored
    step(0, 1, 0, 0, lanes(32'h10, 32'h10, 32'h10, 32'h10));
    idle();
    repeat (3) @(negedge clk);
    chk("nostart_valid", bus.pixelValid, 0);
    chk("nostart_seq", bus.seqErr, 0);

    // basic triple, one-clock latency, four consecutive pixels
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, lanes(32'hBF, 32'hBF, 32'hBF, 32'hBF));
    step(0, 0, 1, 0, lanes(32'h40, 32'h40, 32'h40, 32'h40));
    step(0, 0, 0, 1, lanes(32'h40, 32'h40, 32'h40, 32'h40));
    idle();
    @(negedge clk);
    chk("lat_edge0_valid", bus.pixelValid, 0);
    @(negedge clk);
    chk("lat_edge1_valid", bus.pixelValid, 1);
    chk("basic_pixel", bus.pixel, 32'hBF4040);
    repeat (4) @(negedge clk);
    chk("basic_count", bus.pixelCount, 4);
    chk("basic_drained", bus.pixelValid, 0);

    // lane saturation; second triple also brings pixelCount to PIXEL_TOTAL
    step(0, 1, 0, 0, lanes(32'h100, 32'hFFFFFFFF, 32'hFF, 32'h7));
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 1, '0);
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("sat_lane0", bus.pixel, 32'hFF0000);
    @(negedge clk);
    chk("sat_lane1", bus.pixel, 32'hFF0000);
    @(negedge clk);
    chk("sat_lane2", bus.pixel, 32'hFF0000);
    @(negedge clk);
    chk("sat_lane3", bus.pixel, 32'h070000);
    chk("done_at7", bus.done, 0);
    @(negedge clk);
    chk("count_at8", bus.pixelCount, 8);
    chk("done_at8", bus.done, 1);

    // out-of-order G right after start
    @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    #2 rst = 0;
    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 0, lanes(32'h55, 32'h55, 32'h55, 32'h55));
    idle();
    @(negedge clk);
    chk("seq_flag", bus.seqErr, 1);
    chk("seq_nopixel", bus.pixelValid, 0);
    step(0, 1, 0, 0, lanes(32'h20, 32'h21, 32'h22, 32'h23));
    step(0, 0, 1, 0, lanes(32'h30, 32'h31, 32'h32, 32'h33));
    step(0, 0, 0, 1, lanes(32'h300, 32'h41, 32'h42, 32'h43));
    idle();
    repeat (7) @(negedge clk);
    chk("seq_recover_count", bus.pixelCount, 4);
    chk("seq_sticky", bus.seqErr, 1);

    // back-pressure: one set held, one triple parked in FULL, extra R overflows
    bus.pixelReady = 0;
    step(0, 1, 0, 0, lanes(32'h1, 32'h2, 32'h3, 32'h4));
    step(0, 0, 1, 0, lanes(32'h10, 32'h11, 32'h12, 32'h13));
    step(0, 0, 0, 1, lanes(32'h999, 32'hA0, 32'hB0, 32'hC0));
    idle();
    step(0, 1, 0, 0, lanes(32'h21, 32'h22, 32'h23, 32'h24));
    step(0, 0, 1, 0, lanes(32'h31, 32'h32, 32'h33, 32'h34));
    step(0, 0, 0, 1, lanes(32'h41, 32'h42, 32'h43, 32'h44));
    step(0, 1, 0, 0, lanes(32'h77, 32'h77, 32'h77, 32'h77));
    idle();
    @(negedge clk);
    chk("ovf_flag", bus.ovfErr, 1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_pixel", bus.pixel, 32'h0110FF);
      @(negedge clk);
    end
    bus.pixelReady = 1;
    repeat (12) @(negedge clk);
    chk("release_count", bus.pixelCount, 12);
    chk("release_drained", bus.pixelValid, 0);
    chk("ovf_sticky", bus.ovfErr, 1);

    // asynchronous reset in the middle of emission
    step(0, 1, 0, 0, lanes(32'h5, 32'h6, 32'h7, 32'h8));
    step(0, 0, 1, 0, lanes(32'h5, 32'h6, 32'h7, 32'h8));
    step(0, 0, 0, 1, lanes(32'h5, 32'h6, 32'h7, 32'h8));
    idle();
    repeat (3) @(negedge clk);
    #1 rst = 1;
    #1;
    chk("rst_valid", bus.pixelValid, 0);
    chk("rst_count", bus.pixelCount, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_seq", bus.seqErr, 0);
    chk("rst_ovf", bus.ovfErr, 0);
    @(posedge clk);
    #2 rst = 0;

    // capture needs a fresh start marker after reset
    step(0, 1, 0, 0, lanes(32'h9, 32'h9, 32'h9, 32'h9));
    step(0, 0, 1, 0, lanes(32'h9, 32'h9, 32'h9, 32'h9));
    step(0, 0, 0, 1, lanes(32'h9, 32'h9, 32'h9, 32'h9));
    idle();
    repeat (4) @(negedge clk);
    chk("rearm_valid", bus.pixelValid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
